// File: rtl/btb_update_queue_pkg.sv
// btb_update_queue_pkg
//   Shared types and constants for the BTB update queue.
//   - Vlen              : virtual address width of PCs/targets
//   - BtbUpdqDepth      : default queue depth
//   - btb_update_t      : update record consumed by the banked BTB wrapper
//   - btb_updq_entry_t  : payload held in each queue slot (no valid bit)
//   - btb_updq_state_e  : bank-switch FSM states
package btb_update_queue_pkg;

  localparam int unsigned Vlen         = 64;
  localparam int unsigned BtbUpdqDepth = 4;

  typedef struct packed {
    logic            valid;
    logic [Vlen-1:0] pc;
    logic [Vlen-1:0] target_address;
  } btb_update_t;

  typedef struct packed {
    logic [Vlen-1:0] pc;
    logic [Vlen-1:0] target_address;
  } btb_updq_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StSettle
  } btb_updq_state_e;

endpackage

// File: rtl/btb_updq_fifo.sv
// btb_updq_fifo
//   Generic Depth-entry FIFO with occupancy count and synchronous flush.
//   Full/empty are derived from a PtrW+1 bit count rather than pointer
//   equality, so the pointers can wrap freely (Depth must be a power of two).
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset
//   flush_i  in   empty the FIFO at the next edge; overrides push/pop
//   push_i   in   write wdata_i (ignored when full)
//   wdata_i  in   write data
//   pop_i    in   advance the read pointer (ignored when empty)
//   rdata_o  out  head entry (valid when !empty_o)
//   full_o   out  count == Depth
//   empty_o  out  count == 0
module btb_updq_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// btb_update_queue
//   Buffers resolved-branch BTB updates and drains them one per cycle into
//   the banked BTB wrapper. Owns checkpoint_mode_o (the BTB bank select) and
//   only flips it once every pending update has left the output register, so
//   no update can land in the wrong bank.
//
//   Optional: define BTB_UPDQ_DROP_CNT_EN to build a saturating 16-bit count
//   of dropped updates on drop_cnt_o; otherwise drop_cnt_o is tied to 0.
//
// Ports:
//   clk_i              in   clock
//   rst_i              in   asynchronous active-high reset
//   flush_i            in   drop all queued and in-flight updates
//   update_valid_i     in   resolved update offered
//   update_pc_i        in   PC of the resolved branch
//   update_target_i    in   resolved target
//   update_ready_o     out  queue accepts an update this cycle
//   checkpoint_req_i   in   requested bank (level)
//   checkpoint_mode_o  out  applied bank
//   switch_done_o      out  one-cycle pulse coinciding with a mode change
//   btb_update_o       out  registered update to the BTB wrapper
//   drop_cnt_o         out  dropped-update count (0 unless feature built)
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int unsigned Depth = BtbUpdqDepth
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            update_valid_i,
  input  logic [Vlen-1:0] update_pc_i,
  input  logic [Vlen-1:0] update_target_i,
  output logic            update_ready_o,
  input  logic            checkpoint_req_i,
  output logic            checkpoint_mode_o,
  output logic            switch_done_o,
  output btb_update_t     btb_update_o,
  output logic [15:0]     drop_cnt_o
);

  btb_updq_state_e state_q, state_d;
  logic            mode_q, mode_d;
  logic            switch_done_q, switch_done_d;
  btb_update_t     btb_update_q, btb_update_d;

  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            mode_mismatch;
  btb_updq_entry_t wr_entry, head_entry;

  assign mode_mismatch = (checkpoint_req_i != mode_q);

  assign wr_entry.pc             = update_pc_i;
  assign wr_entry.target_address = update_target_i;

  btb_updq_fifo #(
    .Depth (Depth),
    .Width ($bits(btb_updq_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register: FSM, applied bank and switch pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      mode_q        <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      switch_done_q <= switch_done_d;
    end
  end

  // Next-state logic. The switch target is always the opposite bank, so a
  // request that toggles back mid-drain still completes; IDLE re-evaluates.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    switch_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mode_mismatch) state_d = StDrain;
      end
      StDrain: begin
        // Wait until the last update has also left the output register.
        if (fifo_empty && !btb_update_q.valid) state_d = StSettle;
      end
      StSettle: begin
        // Extra cycle lets the wrapper commit its update under the old bank.
        state_d       = StIdle;
        mode_d        = !mode_q;
        switch_done_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic. Ready drops in the same cycle a bank mismatch appears, and
  // is forced low while reset is asserted.
  always_comb begin
    update_ready_o = !rst_i && (state_q == StIdle) && !mode_mismatch &&
                     !fifo_full && !flush_i;
    push           = update_valid_i && update_ready_o;
    pop            = !fifo_empty && !flush_i;
  end

  // Output register: one valid cycle per dequeued entry; pc/target hold
  // their last value when idle.
  always_comb begin
    btb_update_d       = btb_update_q;
    btb_update_d.valid = 1'b0;
    if (pop) begin
      btb_update_d.valid          = 1'b1;
      btb_update_d.pc             = head_entry.pc;
      btb_update_d.target_address = head_entry.target_address;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btb_update_q <= '0;
    end else begin
      btb_update_q <= btb_update_d;
    end
  end

  assign btb_update_o      = btb_update_q;
  assign checkpoint_mode_o = mode_q;
  assign switch_done_o     = switch_done_q;

`ifdef BTB_UPDQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop_event;

  assign drop_event = update_valid_i && !update_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_event && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            upd_valid;
  logic [Vlen-1:0] upd_pc;
  logic [Vlen-1:0] upd_target;
  logic            upd_ready;
  logic            ckpt_req;
  logic            ckpt_mode;
  logic            switch_done;
  btb_update_t     btb_update;
  logic [15:0]     drop_cnt;

  int checks;
  int failures;

  btb_update_queue #(
    .Depth (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .update_valid_i    (upd_valid),
    .update_pc_i       (upd_pc),
    .update_target_i   (upd_target),
    .update_ready_o    (upd_ready),
    .checkpoint_req_i  (ckpt_req),
    .checkpoint_mode_o (ckpt_mode),
    .switch_done_o     (switch_done),
    .btb_update_o      (btb_update),
    .drop_cnt_o        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        req;
    logic        flush;
    logic        rdy;
    logic        ov;
    logic [63:0] opc;
    logic [63:0] otgt;
    logic        mode;
    logic        done;
    logic [15:0] drops;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop(input logic [15:0] n);
`ifdef BTB_UPDQ_DROP_CNT_EN
    return n;
`else
    return (n == 16'hFFFF) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                       input logic req, input logic fl);
    upd_valid  = v;
    upd_pc     = pc;
    upd_target = tgt;
    ckpt_req   = req;
    flush      = fl;
  endtask

  // Apply inputs just after the rising edge, sample at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int mode_exp [8];
  int done_exp [8];
  int rdy_exp  [8];
  int pulses;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    //                vld pc       tgt      req fl  rdy ov  opc      otgt     md dn drops
    vecs[0]  = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 64'h100, 64'h200, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 64'h104, 64'h204, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 64'h108, 64'h208, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100, 64'h200, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b1, 64'h104, 64'h204, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b1, 64'h108, 64'h208, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[7]  = '{1'b1, 64'h110, 64'h210, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 64'h114, 64'h214, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd0};
    vecs[9]  = '{1'b1, 64'h3f0, 64'h3f0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h110, 64'h210, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b1, 64'h3f4, 64'h3f4, 1'b1, 1'b0, 1'b0, 1'b1, 64'h114, 64'h214, 1'b0, 1'b0, 16'd1};
    vecs[11] = '{1'b1, 64'h3f8, 64'h3f8, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd2};
    vecs[12] = '{1'b1, 64'h3fc, 64'h3fc, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd3};
    vecs[13] = '{1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b1, 1'b1, 16'd4};
    vecs[14] = '{1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 16'd4};
    vecs[15] = '{1'b1, 64'h500, 64'h600, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 16'd4};
    vecs[16] = '{1'b1, 64'h504, 64'h604, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 16'd5};
    vecs[17] = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b1, 1'b0, 16'd6};
    vecs[18] = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b1, 16'd6};
    vecs[19] = '{1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 16'd6};

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, upd_ready}, 64'd0);
    chk("rst_valid", {63'd0, btb_update.valid}, 64'd0);
    chk("rst_pc", btb_update.pc, 64'd0);
    chk("rst_target", btb_update.target_address, 64'd0);
    chk("rst_mode", {63'd0, ckpt_mode}, 64'd0);
    chk("rst_done", {63'd0, switch_done}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    next_cycle();
    rst = 1'b0;

    // Table: back-to-back updates, bank switch with queued entries, drops.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(vecs[i].vld, vecs[i].pc, vecs[i].tgt, vecs[i].req, vecs[i].flush);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {63'd0, upd_ready}, {63'd0, vecs[i].rdy});
      chk($sformatf("v%0d_valid", i), {63'd0, btb_update.valid}, {63'd0, vecs[i].ov});
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_pc", i), btb_update.pc, vecs[i].opc);
        chk($sformatf("v%0d_target", i), btb_update.target_address, vecs[i].otgt);
      end
      chk($sformatf("v%0d_mode", i), {63'd0, ckpt_mode}, {63'd0, vecs[i].mode});
      chk($sformatf("v%0d_done", i), {63'd0, switch_done}, {63'd0, vecs[i].done});
      chk($sformatf("v%0d_drop", i), {48'd0, drop_cnt}, {48'd0, exp_drop(vecs[i].drops)});
    end

    // Flush with a queued entry and a concurrent offered update.
    next_cycle();
    drive(1'b1, 64'h120, 64'h220, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_ready_pre", {63'd0, upd_ready}, 64'd1);
    next_cycle();
    drive(1'b1, 64'h124, 64'h224, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_ready_during", {63'd0, upd_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fl_novalid%0d", i), {63'd0, btb_update.valid}, 64'd0);
    end
    chk("fl_drop", {48'd0, drop_cnt}, {48'd0, exp_drop(16'd6)});
    // Pointers must be coherent after the flush.
    next_cycle();
    drive(1'b1, 64'h128, 64'h228, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_post_gap", {63'd0, btb_update.valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("fl_post_valid", {63'd0, btb_update.valid}, 64'd1);
    chk("fl_post_pc", btb_update.pc, 64'h128);
    chk("fl_post_target", btb_update.target_address, 64'h228);
    next_cycle();
    @(negedge clk);
    chk("fl_post_single", {63'd0, btb_update.valid}, 64'd0);

    // Request pulses 0->1->0 while draining: switch to 1, then straight back.
    next_cycle();
    drive(1'b1, 64'h130, 64'h230, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("pl_ready_drop", {63'd0, upd_ready}, 64'd0);
    next_cycle();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pl_drain_valid", {63'd0, btb_update.valid}, 64'd1);
    chk("pl_drain_pc", btb_update.pc, 64'h130);
    chk("pl_drain_mode", {63'd0, ckpt_mode}, 64'd0);
    mode_exp = '{0, 0, 1, 1, 1, 0, 0, 0};
    done_exp = '{0, 0, 1, 0, 0, 1, 0, 0};
    rdy_exp  = '{0, 0, 0, 0, 0, 1, 1, 1};
    pulses   = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      if (switch_done) pulses++;
      chk($sformatf("pl%0d_mode", i), {63'd0, ckpt_mode}, 64'(mode_exp[i]));
      chk($sformatf("pl%0d_done", i), {63'd0, switch_done}, 64'(done_exp[i]));
      chk($sformatf("pl%0d_ready", i), {63'd0, upd_ready}, 64'(rdy_exp[i]));
    end
    chk("pl_pulses", 64'(pulses), 64'd2);

    // Asynchronous reset in the middle of a drain, with mode at 1.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk("ar_mode1", {63'd0, ckpt_mode}, 64'd1);
    next_cycle();
    drive(1'b1, 64'h140, 64'h240, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("ar_pre_valid", {63'd0, btb_update.valid}, 64'd1);
    chk("ar_pre_pc", btb_update.pc, 64'h140);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, btb_update.valid}, 64'd0);
    chk("ar_pc", btb_update.pc, 64'd0);
    chk("ar_target", btb_update.target_address, 64'd0);
    chk("ar_ready", {63'd0, upd_ready}, 64'd0);
    chk("ar_mode", {63'd0, ckpt_mode}, 64'd0);
    chk("ar_done", {63'd0, switch_done}, 64'd0);
    chk("ar_drop", {48'd0, drop_cnt}, 64'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_rel_mode", {63'd0, ckpt_mode}, 64'd0);
    chk("ar_rel_ready", {63'd0, upd_ready}, 64'd1);
    next_cycle();
    @(negedge clk);
    chk("ar_rel_valid", {63'd0, btb_update.valid}, 64'd0);
    chk("ar_rel_done", {63'd0, switch_done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
